// File: rtl/priority_scan_encoder.sv
// priority_scan_encoder
//   Captures a request vector on an accepted start. It then reports the 1-based index of every
//   set bit, lowest bit first, with one index per out_valid/out_ready handshake. A capture with
//   no set bits reports a single NONE_CODE item. All outputs come from registered state only.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   en          block enable; low aborts any scan and forces idle (no done pulse)
//   start       capture request, honoured only in idle with en high
//   encoder_in  request vector, sampled on the accepted start edge
//   out_ready   consumer accepts binary_out this cycle
//   out_valid   binary_out holds an index or the empty marker
//   binary_out  lowest pending index (bit k -> k+1), NONE_CODE otherwise
//   last        marks the final item of the current scan
//   busy        high whenever not idle
//   hit_count   indices handshaken in the current or most recent scan
//   done        one-cycle pulse after the final handshake
module priority_scan_encoder #(
    parameter int unsigned WIDTH     = 87,
    parameter int unsigned IDX_W     = 7,
    parameter int unsigned NONE_CODE = (2 ** IDX_W) - 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             start,
    input  logic [WIDTH-1:0] encoder_in,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [IDX_W-1:0] binary_out,
    output logic             last,
    output logic             busy,
    output logic [IDX_W-1:0] hit_count,
    output logic             done
);

    // Index 0 is unused and the all-ones code is reserved, so two codes are lost.
    if (WIDTH > (2 ** IDX_W) - 2) begin : g_width_check
        $error("priority_scan_encoder: WIDTH does not fit in IDX_W");
    end

    localparam logic [WIDTH-1:0] PendOne  = {{(WIDTH - 1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0] HitOne   = {{(IDX_W - 1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0] NoneCode = IDX_W'(NONE_CODE);

    typedef enum logic [1:0] {StIdle, StScan, StEmpty} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic [IDX_W-1:0] hit_count_q, hit_count_d;
    logic             done_q, done_d;

    logic [IDX_W-1:0] low_idx;
    logic             single_bit;

    // Lowest set bit wins: scanning downwards lets the lowest hit overwrite the others.
    always_comb begin
        low_idx = NoneCode;
        for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                low_idx = IDX_W'(i + 1);
            end
        end
    end

    // x & (x - 1) clears the lowest set bit; zero result means at most one bit was set.
    assign single_bit = (pending_q != '0) && ((pending_q & (pending_q - PendOne)) == '0);

    always_comb begin
        out_valid  = (state_q != StIdle);
        busy       = (state_q != StIdle);
        binary_out = NoneCode;
        last       = 1'b0;
        unique case (state_q)
            StScan: begin
                binary_out = low_idx;
                last       = single_bit;
            end
            StEmpty: begin
                last = 1'b1;
            end
            default: ;
        endcase
        hit_count = hit_count_q;
        done      = done_q;
    end

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        hit_count_d = hit_count_q;
        done_d      = 1'b0;
        if (!en) begin
            state_d   = StIdle;
            pending_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        pending_d   = encoder_in;
                        hit_count_d = '0;
                        state_d     = (encoder_in != '0) ? StScan : StEmpty;
                    end
                end
                StScan: begin
                    if (out_ready) begin
                        pending_d   = pending_q & (pending_q - PendOne);
                        hit_count_d = hit_count_q + HitOne;
                        if (single_bit) begin
                            state_d = StIdle;
                            done_d  = 1'b1;
                        end
                    end
                end
                StEmpty: begin
                    if (out_ready) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end
                default: begin
                    state_d   = StIdle;
                    pending_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            pending_q   <= '0;
            hit_count_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            hit_count_q <= hit_count_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: doc/priority_scan_encoder.md
Name: priority_scan_encoder

Overview:
- Parametrised, sequential successor to the combinational 87-input priority encoder.
- Captures a request vector on `start`, then emits the 1-based index of every set bit, lowest bit first, one index per valid/ready handshake.
- Sits between request-flag generators and downstream index consumers that must service all hits, not only the highest-priority one.
- Keeps the existing index convention: bit k reports as k+1, and the all-ones code means "none / disabled".

Parameters:
- WIDTH, 87: number of request bits.
- IDX_W, 7: index width. Must satisfy WIDTH <= 2^IDX_W - 2; an elaboration-time check is required.
- NONE_CODE, 2^IDX_W - 1 (127 at default): code driven when there is no valid index.

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- en, input, 1: block enable. Low aborts any scan and forces idle.
- start, input, 1: capture request; sampled only in IDLE with en=1.
- encoder_in, input, WIDTH: request vector, sampled on the accepted start edge only.
- out_ready, input, 1: consumer accepts binary_out this cycle.
- out_valid, output, 1: binary_out holds a valid index or the empty marker.
- binary_out, output, IDX_W: 1-based index of the lowest pending bit; NONE_CODE when not valid or when the capture was empty.
- last, output, 1: qualifies the final item of the current scan.
- busy, output, 1: high in any state other than IDLE.
- hit_count, output, IDX_W: number of indices handshaken in the current or most recent scan.
- done, output, 1: one-cycle pulse after the final handshake.

Behaviour:
- Reset (async assert, sync release): state=IDLE, pending=0, out_valid=0, binary_out=NONE_CODE, last=0, busy=0, hit_count=0, done=0.
- States: IDLE, SCAN, EMPTY.
- IDLE, start=1 and en=1 at edge T:
  - pending <= encoder_in; hit_count <= 0.
  - pending nonzero: go to SCAN. Zero: go to EMPTY.
  - out_valid is high from T+1, so latency from start to first item is 1 cycle.
- SCAN:
  - out_valid=1; binary_out = (index of lowest set bit of pending) + 1.
  - last=1 when exactly one bit of pending is set.
  - Handshake (out_valid & out_ready): clear that bit, increment hit_count, and present the next index in the following cycle.
  - Handshake with last=1: go to IDLE; done=1 for the next cycle.
  - out_ready low: binary_out and last hold stable. No output change is allowed without a handshake.
- EMPTY:
  - out_valid=1, binary_out=NONE_CODE, last=1; hit_count stays 0.
  - On handshake: go to IDLE with a done pulse.
- en=0 in any state, checked at the clock edge:
  - Next state IDLE, pending cleared, no done pulse; hit_count holds its value.
  - Outputs depend only on registered state, so out_valid falls the cycle after en falls.
- start while busy is ignored; encoder_in changes outside the capture edge have no effect.
- start in IDLE with en=0 is ignored.
- When out_valid=0, binary_out=NONE_CODE.
- Priority is always lowest bit index first, matching the predecessor ordering.
- hit_count never exceeds WIDTH and never wraps.
- Outputs are functions of registered state only; there is no combinational path from any input to any output.
- Sustained throughput is 1 index/cycle with out_ready held high.
- Back-to-back scans: a start in the cycle after done is accepted; done and the new capture do not conflict.

Test Plan:
- Reset, then start with encoder_in bits {0,5,86} set and out_ready=1 -> outputs 1, 6, 87 on consecutive cycles; last only with 87; done pulse next cycle; hit_count=3.
- Start with encoder_in=0 -> one item with binary_out=127, last=1; done after handshake; hit_count=0.
- Bits {3,4}, out_ready toggling 0,1,0,0,1 -> binary_out=4 held until the first accept, then 5 held until the second accept; no dropped or duplicated index.
- Bits {10,20,30}; drop en after the first handshake -> state IDLE next cycle, out_valid=0, binary_out=127, no done, hit_count=1.
- Start pulsed again mid-scan with a different vector -> ignored, original sequence completes unchanged.
- All 87 bits set, out_ready=1 -> indices 1..87 in order over 87 cycles; hit_count=87; rst_n pulsed low mid-run instead -> all outputs immediately at reset values.
